// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared definitions for the RAM write/read-back test sequencer.
//   - ST_* : 3-bit state encodings used by the controller FSM
//   - state_e : enumerated state type built on the ST_* encodings
//   - pat() : test pattern, pattern(a) = a + seed; callers truncate to DATA_W
package ram_bist_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_WRITE = ST_WRITE,
        S_READ  = ST_READ,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_e;

    // Truncating the 32-bit sum to DATA_W gives (a + seed) mod 2**DATA_W,
    // identical to first reducing a to its low DATA_W bits.
    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed);
        return addr + seed;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: single-port block RAM bus between the BIST sequencer and the RAM.
//   ram_en      : RAM enable (ena)
//   ram_we      : RAM write enable (wea)
//   ram_addr    : RAM address (addra)
//   ram_wr_data : RAM write data (dina)
//   ram_rd_data : RAM read data (douta)
// master = sequencer side, slave = RAM side.
interface ram_bist_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (
        output ram_en,
        output ram_we,
        output ram_addr,
        output ram_wr_data,
        input  ram_rd_data
    );

    modport slave (
        input  ram_en,
        input  ram_we,
        input  ram_addr,
        input  ram_wr_data,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: read-latency delay line and read-back comparator.
//   clk, rst_n     : clock, synchronous active-low reset
//   clr            : clear err_cnt / first_err_addr (test start)
//   flush          : drop everything in flight (abort); no compare this cycle
//   issue          : a read address is on the RAM bus this cycle
//   issue_addr     : that read address
//   rd_data        : RAM read data
//   err_cnt        : saturating mismatch count
//   first_err_addr : address of the first mismatch since clr
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int              ADDR_W = 5,
    parameter int              DATA_W = 8,
    parameter int              RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              flush,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [DATA_W-1:0] exp_q  [RD_LAT];
    logic [ADDR_W:0]   err_q;
    logic [ADDR_W-1:0] first_q;
    logic              mismatch;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (&v) ? v : v + (ADDR_W+1)'(1);
    endfunction

    // Stage 0 is loaded on the edge the RAM samples the read address; the
    // tail lines up with ram_rd_data RD_LAT cycles later.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q[0] <= issue_addr;
        exp_q[0]  <= DATA_W'(pat(32'(issue_addr), 32'(SEED)));
        for (int i = 1; i < RD_LAT; i++) begin
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
        end
    end

    // Tail of the delay line: compare against returned data
    assign mismatch = vld_q[RD_LAT-1] && !flush && (rd_data != exp_q[RD_LAT-1]);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            err_q   <= '0;
            first_q <= '0;
        end else if (mismatch) begin
            err_q <= sat_inc(err_q);
            if (err_q == '0) begin
                first_q <= addr_q[RD_LAT-1];
            end
        end
    end

    assign err_cnt        = err_q;
    assign first_err_addr = first_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back BIST sequencer for a single-port block RAM.
// Fills addresses 0..DEPTH-1 with pat(a), reads them back and counts mismatches.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : one-cycle request, honoured in IDLE or DONE
//   abort          : return to IDLE from WRITE/READ/DRAIN, beats start
//   ram            : RAM bus (master side), all bus outputs registered
//   busy           : in WRITE, READ or DRAIN
//   done           : in DONE
//   pass           : done with zero mismatches
//   err_cnt        : saturating mismatch count
//   first_err_addr : first mismatching address, 0 if none
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = 5,
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 32,
    parameter int                RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    ram_bist_if.master        ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        drain_q, drain_d;
    logic              en_q, en_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q;
    logic              clr;
    logic              flush;

    function automatic logic [DATA_W-1:0] pat_w(input logic [ADDR_W-1:0] a);
        return DATA_W'(pat(32'(a), 32'(SEED)));
    endfunction

    assign busy_q = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign flush  = abort && busy_q;

    // Bus outputs are computed one cycle ahead so the RAM sees registered signals.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        en_d      = 1'b0;
        we_d      = 1'b0;
        wr_data_d = wr_data_q;
        clr       = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_d   = S_WRITE;
                    addr_d    = '0;
                    en_d      = 1'b1;
                    we_d      = 1'b1;
                    wr_data_d = pat_w('0);
                    clr       = 1'b1;
                end
            end
            S_WRITE: begin
                en_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    // Straight into READ with no idle cycle
                    state_d = S_READ;
                    addr_d  = '0;
                end else begin
                    we_d      = 1'b1;
                    addr_d    = addr_q + 1'b1;
                    wr_data_d = pat_w(addr_q + 1'b1);
                end
            end
            S_READ: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    en_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            en_d    = 1'b0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            drain_q   <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            en_q      <= en_d;
            we_q      <= we_d;
            wr_data_q <= wr_data_d;
        end
    end

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .SEED   (SEED)
    ) u_cmp (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .flush          (flush),
        .issue          (en_q && !we_q),
        .issue_addr     (addr_q),
        .rd_data        (ram.ram_rd_data),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    assign ram.ram_en      = en_q;
    assign ram.ram_we      = we_q;
    assign ram.ram_addr    = addr_q;
    assign ram.ram_wr_data = wr_data_q;

    assign busy = busy_q;
    assign done = (state_q == S_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;

    always #5 clk = ~clk;

    ram_bist_if #(.ADDR_W(5), .DATA_W(8)) ram_if1 ();
    ram_bist_if #(.ADDR_W(5), .DATA_W(8)) ram_if2 ();

    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [5:0] err1, err2;
    logic [4:0] first1, first2;

    ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(1), .SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ram(ram_if1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(first1)
    );

    ram_bist_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(2), .SEED(8'hA5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ram(ram_if2.master),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_addr(first2)
    );

    // Behavioural RAMs; mask[a] XORs the stored word on read (fault inject)
    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];
    logic [7:0] mask1 [32];
    logic [7:0] mask2 [32];
    logic [7:0] rd1_p0, rd2_p0, rd2_p1;

    always @(posedge clk) begin
        if (ram_if1.ram_en) begin
            if (ram_if1.ram_we) mem1[ram_if1.ram_addr] <= ram_if1.ram_wr_data;
            else rd1_p0 <= mem1[ram_if1.ram_addr] ^ mask1[ram_if1.ram_addr];
        end
        if (ram_if2.ram_en) begin
            if (ram_if2.ram_we) mem2[ram_if2.ram_addr] <= ram_if2.ram_wr_data;
            else rd2_p0 <= mem2[ram_if2.ram_addr] ^ mask2[ram_if2.ram_addr];
        end
        rd2_p1 <= rd2_p0;
    end
    assign ram_if1.ram_rd_data = rd1_p0;
    assign ram_if2.ram_rd_data = rd2_p1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pattern, and readback results from the fault masks
    function automatic logic [7:0] pat_m(input int a);
        return 8'(a + 'hA5);
    endfunction

    function automatic int model_cnt(input logic [7:0] m [32]);
        int c = 0;
        for (int a = 0; a < 32; a++) begin
            logic [7:0] rb;
            rb = pat_m(a) ^ m[a];
            if (rb != pat_m(a)) c++;
        end
        return (c > 63) ? 63 : c;
    endfunction

    function automatic int model_first(input logic [7:0] m [32]);
        for (int a = 0; a < 32; a++) begin
            if ((pat_m(a) ^ m[a]) != pat_m(a)) return a;
        end
        return 0;
    endfunction

    task automatic clear_masks();
        for (int a = 0; a < 32; a++) begin
            mask1[a] = 8'h00;
            mask2[a] = 8'h00;
        end
    endtask

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } bus_t;

    // One complete test from a start pulse; called on a negedge.
    task automatic run_full(input string tag);
        int   t1 = 0;
        int   t2 = 0;
        int   first_en = -1;
        int   last_en = -1;
        int   bad = 0;
        int   m1c, m2c;
        bus_t q[$];
        bus_t e;
        start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (ram_if1.ram_en) begin
                e.we = ram_if1.ram_we; e.addr = ram_if1.ram_addr; e.data = ram_if1.ram_wr_data;
                q.push_back(e);
                if (first_en < 0) first_en = n;
                last_en = n;
            end
            if (done1 && t1 == 0) t1 = n;
            if (done2 && t2 == 0) t2 = n;
            if (t1 != 0 && t2 != 0) break;
        end
        chk({tag, " done_lat1"}, t1, 66);
        chk({tag, " done_lat2"}, t2, 67);
        chk({tag, " bus_span"}, last_en - first_en + 1, 64);
        if (q.size() != 64) bad++;
        for (int i = 0; i < q.size() && i < 64; i++) begin
            if (i < 32) begin
                if (q[i].we !== 1'b1 || q[i].addr !== 5'(i) || q[i].data !== pat_m(i)) bad++;
            end else begin
                if (q[i].we !== 1'b0 || q[i].addr !== 5'(i - 32)) bad++;
            end
        end
        chk({tag, " bus_seq_bad"}, bad, 0);
        if (q.size() >= 32) begin
            chk({tag, " wr_first"}, q[0].data, 8'hA5);
            chk({tag, " wr_last"}, q[31].data, 8'hC4);
        end
        chk({tag, " addr_hold"}, ram_if1.ram_addr, 31);
        chk({tag, " en_drain"}, ram_if1.ram_en, 0);
        m1c = model_cnt(mask1);
        m2c = model_cnt(mask2);
        chk({tag, " err1"}, err1, m1c);
        chk({tag, " first1"}, first1, model_first(mask1));
        chk({tag, " pass1"}, pass1, (m1c == 0));
        chk({tag, " err2"}, err2, m2c);
        chk({tag, " first2"}, first2, model_first(mask2));
        chk({tag, " pass2"}, pass2, (m2c == 0));
    endtask

    typedef struct {
        int         fa;
        int         fb;
        int         fc;
        logic [7:0] x;
        int         exp_err;
        int         exp_first;
        logic       exp_pass;
    } vec_t;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   found;
        int   bad;
        int   seen;
        vecs[0] = '{-1, -1, -1, 8'h00, 0, 0,  1'b1};
        vecs[1] = '{ 5, -1, -1, 8'h01, 1, 5,  1'b0};
        vecs[2] = '{ 3, 17, 31, 8'h10, 3, 3,  1'b0};
        vecs[3] = '{31, -1, -1, 8'h80, 1, 31, 1'b0};
        vecs[4] = '{ 0, -1, -1, 8'hFF, 1, 0,  1'b0};
        vecs[5] = '{ 0, 31, -1, 8'h01, 2, 0,  1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        clear_masks();
        repeat (3) @(negedge clk);
        chk("rst en1", ram_if1.ram_en, 0);
        chk("rst addr1", ram_if1.ram_addr, 0);
        chk("rst busy1", busy1, 0);
        chk("rst done1", done1, 0);
        chk("rst pass1", pass1, 0);
        chk("rst err1", err1, 0);
        chk("rst busy2", busy2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-scenario table
        foreach (vecs[i]) begin
            clear_masks();
            if (vecs[i].fa >= 0) begin mask1[vecs[i].fa] = vecs[i].x; mask2[vecs[i].fa] = vecs[i].x; end
            if (vecs[i].fb >= 0) begin mask1[vecs[i].fb] = vecs[i].x; mask2[vecs[i].fb] = vecs[i].x; end
            if (vecs[i].fc >= 0) begin mask1[vecs[i].fc] = vecs[i].x; mask2[vecs[i].fc] = vecs[i].x; end
            run_full($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_err1", i), err1, vecs[i].exp_err);
            chk($sformatf("vec%0d tbl_first1", i), first1, vecs[i].exp_first);
            chk($sformatf("vec%0d tbl_pass1", i), pass1, vecs[i].exp_pass);
            chk($sformatf("vec%0d tbl_err2", i), err2, vecs[i].exp_err);
            chk($sformatf("vec%0d tbl_first2", i), first2, vecs[i].exp_first);
        end

        // Abort during READ at address 10, with a fault already counted at 2
        clear_masks();
        mask1[2] = 8'h01; mask2[2] = 8'h01;
        start = 1'b1;
        found = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (ram_if1.ram_en && !ram_if1.ram_we && ram_if1.ram_addr == 5'd10) begin
                found = 1;
                break;
            end
        end
        chk("abort reached_addr10", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort en1", ram_if1.ram_en, 0);
        chk("abort busy1", busy1, 0);
        chk("abort done1", done1, 0);
        chk("abort busy2", busy2, 0);
        chk("abort err1_kept", err1, 1);
        chk("abort first1_kept", first1, 2);
        chk("abort err2_kept", err2, 1);
        chk("abort first2_kept", first2, 2);
        seen = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (done1 || done2 || busy1) seen++;
        end
        chk("abort no_done", seen, 0);
        clear_masks();
        run_full("after_abort");

        // Reset pulse during WRITE at address 20; start during reset ignored
        found = 0;
        start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (ram_if1.ram_en && ram_if1.ram_we && ram_if1.ram_addr == 5'd20) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid reached_addr20", found, 1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("rst_mid en1", ram_if1.ram_en, 0);
        chk("rst_mid we1", ram_if1.ram_we, 0);
        chk("rst_mid addr1", ram_if1.ram_addr, 0);
        chk("rst_mid wdata1", ram_if1.ram_wr_data, 0);
        chk("rst_mid busy1", busy1, 0);
        chk("rst_mid done1", done1, 0);
        chk("rst_mid err1", err1, 0);
        chk("rst_mid first1", first1, 0);
        chk("rst_mid en2", ram_if2.ram_en, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid start_ignored", busy1, 0);
        run_full("after_rst");

        // Start held through the whole test, then still high in DONE
        start = 1'b1;
        bad = 0;
        for (int n = 1; n <= 65; n++) begin
            @(negedge clk);
            if (!busy1 || done1) bad++;
        end
        chk("held no_restart", bad, 0);
        @(negedge clk);
        chk("held done_at_66", done1, 1);
        @(negedge clk);
        chk("held restart_busy", busy1, 1);
        chk("held restart_done", done1, 0);
        chk("held restart_we", ram_if1.ram_we, 1);
        chk("held restart_addr", ram_if1.ram_addr, 0);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("held abort_idle", busy1, 0);

        // start and abort together in IDLE: stay in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("pair busy1", busy1, 0);
        chk("pair en1", ram_if1.ram_en, 0);
        @(negedge clk);
        chk("pair still_idle", busy1, 0);

        // abort in DONE is ignored; start+abort in DONE stays in DONE
        run_full("done_abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("done_abort done1", done1, 1);
        chk("done_abort pass1", pass1, 1);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("done_pair done1", done1, 1);

        // Randomised fault maps against the model
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 32; a++) begin
                mask1[a] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                mask2[a] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            run_full($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
